// File: rtl/fractal_pkg.sv
// Shared constants, scan-reader state encoding and iteration-count colour map
// for the fractal frame buffer, its writer and the VGA timing block.
package fractal_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned MAX_ITER     = 100;
  localparam int unsigned COLOUR_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2
  } scan_state_t;

  // Points inside the set are black; others spread the low count bits over RGB.
  function automatic logic [COLOUR_W-1:0] colour_map(input logic [5:0] cnt_lo,
                                                     input logic       in_set);
    if (in_set) return 12'h000;
    return {cnt_lo[1:0], 2'b11, cnt_lo[5:2], ~cnt_lo[3:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; simultaneous push and
// pop are both honoured. DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             Clk_100M,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge Clk_100M) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge Clk_100M) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_scan_reader.sv
// Raster-order frame-buffer reader: prefetches iteration counts into a small
// FIFO and pops one per visible pixel tick into the registered colour output.
module fb_scan_reader #(
  parameter int unsigned H_ACTIVE   = fractal_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = fractal_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_ITER   = fractal_pkg::MAX_ITER
) (
  input  logic              Clk_100M,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_y,
  input  logic              display,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_r,
  input  logic [DATA_W-1:0] rdata,
  output logic [11:0]       colour,
  output logic              underflow
);

  import fractal_pkg::*;

  localparam int unsigned FRAME = H_ACTIVE * V_ACTIVE;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_t       state;
  scan_state_t       nxt;
  logic [9:0]        pixel_y_q;
  logic              frame_end_c;
  logic              rd_pend;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_en_d;
  logic [11:0]       colour_d;
  logic              underflow_d;
  logic              push_c;
  logic              pop_c;
  logic              clear_c;
  logic [DATA_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              empty;
  logic [LVL_W:0]    outstanding_c;

  assign frame_end_c   = (pixel_y == 10'(V_ACTIVE)) && (pixel_y_q < 10'(V_ACTIVE));
  assign push_c        = rd_pend & (state == ST_FILL);
  assign clear_c       = (state != ST_FILL);
  assign outstanding_c = (LVL_W+1)'(level) + (LVL_W+1)'(rd_en) + (LVL_W+1)'(rd_pend);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .Clk_100M (Clk_100M),
    .reset    (reset),
    .clear    (clear_c),
    .push     (push_c),
    .pop      (pop_c),
    .wdata    (rdata),
    .rdata    (head),
    .level    (level),
    .empty    (empty)
  );

  always_ff @(posedge Clk_100M) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!display) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (frame_end_c) nxt = ST_FLUSH;
        ST_FLUSH: nxt = ST_FILL;
        ST_FILL:  if (frame_end_c) nxt = ST_FLUSH;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en_d     = 1'b0;
    addr_d      = addr_r;
    ptr_d       = ptr;
    colour_d    = colour;
    underflow_d = underflow;
    pop_c       = 1'b0;
    case (state)
      ST_FLUSH: begin
        ptr_d    = '0;
        addr_d   = '0;
        colour_d = 12'h000;
      end
      ST_FILL: begin
        // Reads stop one cycle early when leaving FILL so nothing lands after.
        if (nxt == ST_FILL && outstanding_c < (LVL_W+1)'(FIFO_DEPTH) &&
            ptr < ADDR_W'(FRAME)) begin
          rd_en_d = 1'b1;
          addr_d  = ptr;
          ptr_d   = ptr + ADDR_W'(1);
        end
        if (p_tick) begin
          if (!video_on) begin
            colour_d = 12'h000;
          end else if (empty) begin
            colour_d    = 12'hF00;
            underflow_d = 1'b1;
          end else begin
            pop_c    = 1'b1;
            colour_d = colour_map(head[5:0], head == DATA_W'(MAX_ITER));
          end
        end
      end
      default: colour_d = 12'h000;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      rd_en     <= 1'b0;
      addr_r    <= '0;
      ptr       <= '0;
      colour    <= 12'h000;
      underflow <= 1'b0;
      rd_pend   <= 1'b0;
      pixel_y_q <= '0;
    end else begin
      rd_en     <= rd_en_d;
      addr_r    <= addr_d;
      ptr       <= ptr_d;
      colour    <= colour_d;
      underflow <= underflow_d;
      rd_pend   <= rd_en;
      pixel_y_q <= pixel_y;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader on a reduced 16x12 raster with a small VGA-like
// timing generator; colours are checked through an expected-value queue.
module tb_fb_scan_reader;

  localparam int H     = 16;
  localparam int V     = 12;
  localparam int H_TOT = 24;
  localparam int V_TOT = 16;
  localparam int FRAME = H * V;
  localparam int DEPTH = 8;

  logic        Clk_100M = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  pixel_y;
  logic        display;
  logic        rd_en;
  logic [18:0] addr_r;
  logic [7:0]  rdata;
  logic [11:0] colour;
  logic        underflow;
  logic        tick_q = 1'b0;

  always #5 Clk_100M = ~Clk_100M;

  fb_scan_reader #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_W     (19),
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH),
    .MAX_ITER   (100)
  ) dut (
    .Clk_100M  (Clk_100M),
    .reset     (reset),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .pixel_y   (pixel_y),
    .display   (display),
    .rd_en     (rd_en),
    .addr_r    (addr_r),
    .rdata     (rdata),
    .colour    (colour),
    .underflow (underflow)
  );

  // Frame-buffer model: count at address a is a[7:0]+5, one-clock read latency.
  always @(posedge Clk_100M) if (rd_en) rdata <= addr_r[7:0] + 8'd5;
  always @(posedge Clk_100M) tick_q <= p_tick;

  logic [11:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int m_state, m_py, pix_idx, rd_cnt, rd_exp, last_addr;
  int sub, gx, gy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_colour(input int idx);
    logic [7:0] c;
    case (idx)
      0:  return 12'h71A;
      1:  return 12'hB19;
      10: return 12'hF30;
      95: return 12'h000;
      default: begin
        c = 8'(idx + 5);
        if (c == 8'd100) return 12'h000;
        return {c[1:0], 2'b11, c[5:2], ~c[3:0]};
      end
    endcase
  endfunction

  task automatic drive();
    p_tick   = (sub == 0);
    video_on = (gx < H) && (gy < V);
    pixel_y  = 10'(gy);
  endtask

  task automatic frame_check();
    chk("frame_pops", pix_idx, FRAME);
    chk("frame_reads", rd_cnt, FRAME);
    chk("frame_last_addr", last_addr, FRAME - 1);
    chk("frame_underflow", int'(underflow), 0);
  endtask

  // One clock: log the expected colour for the sampled tick, advance the
  // reference state, check any read, then drive the next cycle's inputs.
  task automatic step();
    @(posedge Clk_100M);
    #1;
    if (p_tick) begin
      if (reset || m_state != 2 || !video_on) exp_q.push_back(12'h000);
      else begin
        exp_q.push_back(exp_colour(pix_idx));
        pix_idx++;
      end
    end
    if (reset) m_state = 0;
    else if (!display) m_state = 0;
    else if (m_state != 1 && int'(pixel_y) == V && m_py < V) begin
      if (m_state == 2) frame_check();
      m_state = 1;
      pix_idx = 0;
      rd_cnt  = 0;
      rd_exp  = 0;
    end else if (m_state == 1) m_state = 2;
    m_py = reset ? 0 : int'(pixel_y);
    if (rd_en) begin
      chk("rd_state", m_state, 2);
      chk("rd_addr", int'(addr_r), rd_exp);
      last_addr = int'(addr_r);
      rd_exp++;
      rd_cnt++;
    end
    sub++;
    if (sub == 4) begin
      sub = 0;
      gx++;
      if (gx == H_TOT) begin
        gx = 0;
        gy++;
        if (gy == V_TOT) gy = 0;
      end
    end
    drive();
  endtask

  task automatic wait_flush();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step();
      if (m_state == 1) done = 1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_flush: no frame end within 4000 clocks");
    end
  endtask

  task automatic wait_pixel(input int x, input int y);
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step();
      if (sub == 0 && gx == x && gy == y) done = 1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_pixel: pixel (%0d,%0d) not reached", x, y);
    end
  endtask

  initial begin
    reset = 1'b1; display = 1'b1;
    sub = 0; gx = 0; gy = 0;
    m_state = 0; m_py = 0; pix_idx = 0; rd_cnt = 0; rd_exp = 0; last_addr = -1;
    drive();

    fork
      forever begin
        @(negedge Clk_100M);
        if (tick_q) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_underrun: colour 0x%0h with nothing expected", colour);
          end else begin
            chk("colour", int'(colour), int'(exp_q.pop_front()));
          end
        end
      end
    join_none

    repeat (3) step();
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_addr", int'(addr_r), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_underflow", int'(underflow), 0);
    reset = 1'b0;

    wait_flush();
    repeat (20) step();
    chk("prefetch_reads", rd_cnt, DEPTH);
    chk("prefetch_next_addr", rd_exp, DEPTH);
    repeat (200) step();
    chk("prefetch_stall", rd_cnt, DEPTH);

    wait_flush();

    wait_pixel(H / 2, V / 2);
    reset = 1'b1;
    step();
    chk("midreset_rd_en", int'(rd_en), 0);
    chk("midreset_addr", int'(addr_r), 0);
    chk("midreset_colour", int'(colour), 0);
    chk("midreset_underflow", int'(underflow), 0);
    reset = 1'b0;

    wait_flush();
    wait_flush();

    wait_pixel(5, 3);
    display = 1'b0;
    repeat (8) step();
    chk("display_off_rd_en", int'(rd_en), 0);
    chk("display_off_colour", int'(colour), 0);
    display = 1'b1;

    wait_flush();
    wait_pixel(2, 2);
    chk("recover_underflow", int'(underflow), 0);
    repeat (8) step();
    @(negedge Clk_100M);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
